uart_wb_initiator: RTL

Wishbone-style bus initiator that issues single 8-bit read/write transactions to the `uart` peripheral's slave port, using its `wb_clk`/`wb_stb`/`wb_ack` four-phase handshake. It sits between a simple valid/ready command source (CPU core, test sequencer or debug bridge) and the UART register file (TX, RX, frequency divider). One transaction is outstanding at a time, and every accepted request produces exactly one response pulse.

---
 rtl/uart_wb_initiator_pkg.sv | 15 +
 rtl/uart_wb_initiator_wb_watchdog.sv | 18 +
 rtl/uart_wb_initiator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_wb_initiator_pkg.sv
// uart_wb_initiator_pkg: shared constants for the uart slave port and its initiator
// Holds register addresses, wb_we encoding and initiator state encodings.
// Optional timeout logic in the initiator is enabled by UART_WB_TIMEOUT_EN.
package uart_wb_initiator_pkg;
   localparam logic [1:0] ADDR_TX       = 2'b00;
   localparam logic [1:0] ADDR_RX       = 2'b01;
   localparam logic [1:0] ADDR_FREQ_DIV = 2'b10;
   localparam logic WB_WE_WRITE = 1'b0;
   localparam logic WB_WE_READ  = 1'b1;
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_ACK = 2'b01,
      WAIT_REL = 2'b10
   } state_t;
endpackage

// File: rtl/uart_wb_initiator_wb_watchdog.sv
// wb_watchdog: 16-bit up-counter cleared by clr, counting while en, flagging terminal count
// Ports: clk, reset (async, active-high), clr (load zero), en (count), tc (count == LIMIT).
module wb_watchdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [15:0] count;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clr) count <= '0;
      else if (en) count <= count + 16'd1;
   assign tc = count == 16'(LIMIT);
endmodule

// File: rtl/uart_wb_initiator.sv
// uart_wb_initiator: single-transaction wishbone-style initiator for the uart slave port
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_write/req_addr/req_wdata
// command side; rsp_valid/rsp_rdata/rsp_err response pulse; wb_addr/wb_data_out/wb_data_in/
// wb_we (low = write)/wb_clk/wb_stb/wb_ack slave side. All outputs registered.
// Define UART_WB_TIMEOUT_EN to abort a handshake phase after TIMEOUT_CYCLES clocks.
module uart_wb_initiator
   import uart_wb_initiator_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [1:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data_out,
   input  logic [7:0] wb_data_in,
   output logic       wb_we,
   output logic       wb_clk,
   output logic       wb_stb,
   input  logic       wb_ack
);
   state_t     state, state_n;
   logic       req_ready_n, rsp_valid_n, rsp_err_n, wb_we_n, wb_clk_n, wb_stb_n;
   logic [7:0] rsp_rdata_n, wb_data_out_n;
   logic [1:0] wb_addr_n;
   logic       timeout;
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("uart_wb_initiator: TIMEOUT_CYCLES out of range 1..65535");
   end
`ifdef UART_WB_TIMEOUT_EN
   // counter restarts on every state change, so each handshake phase gets its own budget
   wb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk  (clk),
      .reset(reset),
      .clr  (state_n != state),
      .en   (state != IDLE),
      .tc   (timeout)
   );
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_n       = state;
      rsp_valid_n   = 1'b0;
      rsp_err_n     = 1'b0;
      rsp_rdata_n   = rsp_rdata;
      wb_we_n       = wb_we;
      wb_clk_n      = wb_clk;
      wb_stb_n      = wb_stb;
      wb_addr_n     = wb_addr;
      wb_data_out_n = wb_data_out;
      case (state)
         IDLE:
            if (req_valid && req_ready) begin
               state_n       = WAIT_ACK;
               wb_addr_n     = req_addr;
               wb_data_out_n = req_wdata;
               wb_we_n       = req_write ? WB_WE_WRITE : WB_WE_READ;
               wb_stb_n      = 1'b1;
               wb_clk_n      = 1'b1;
            end
         WAIT_ACK:
            // an acknowledge takes priority over a timeout landing in the same cycle
            if (wb_ack) begin
               state_n     = WAIT_REL;
               rsp_rdata_n = wb_we == WB_WE_READ ? wb_data_in : 8'h00;
               wb_clk_n    = 1'b0;
            end else if (timeout) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b1;
               rsp_rdata_n = 8'h00;
               wb_clk_n    = 1'b0;
               wb_stb_n    = 1'b0;
            end
         WAIT_REL:
            if (!wb_ack) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               wb_stb_n    = 1'b0;
            end else if (timeout) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b1;
               rsp_rdata_n = 8'h00;
               wb_clk_n    = 1'b0;
               wb_stb_n    = 1'b0;
            end
         default: state_n = IDLE;
      endcase
      // ready follows the next state so a new command can be taken alongside rsp_valid
      req_ready_n = state_n == IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= 8'h00;
         wb_we       <= WB_WE_READ;
         wb_clk      <= 1'b0;
         wb_stb      <= 1'b0;
         wb_addr     <= 2'b00;
         wb_data_out <= 8'h00;
      end else begin
         state       <= state_n;
         req_ready   <= req_ready_n;
         rsp_valid   <= rsp_valid_n;
         rsp_err     <= rsp_err_n;
         rsp_rdata   <= rsp_rdata_n;
         wb_we       <= wb_we_n;
         wb_clk      <= wb_clk_n;
         wb_stb      <= wb_stb_n;
         wb_addr     <= wb_addr_n;
         wb_data_out <= wb_data_out_n;
      end
endmodule
